// File: rtl/rs_pkg.sv
// Shared RS(31,k) decoder definitions: codeword geometry and receive-FIFO controller states.
// Pure declarations, no logic.
// Counter width is derived so that the symbol index 0..N-1 always fits.
package rs_pkg;
  localparam int N     = 31;
  localparam int SYM_W = 5;
  localparam int CW    = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fifo_state_t;

  localparam logic [CW-1:0] LAST_SYM = CW'(N - 1);
  localparam logic [CW-1:0] PREV_SYM = CW'(N - 2);
endpackage

// File: rtl/fifo_ctrl_if.sv
// Control/status bundle between the receive-FIFO sequencer and the decoder top level.
// Wires only, no latency.
// master = sequencer (drives FIFO controls and status), slave = top level / FIFO side.
interface fifo_ctrl_if;
  import rs_pkg::*;

  logic          in_start;
  logic          csee_ready;
  logic          shift_fifo;
  logic          hold_fifo;
  logic          en_infifo;
  logic          en_outfifo;
  logic          out_valid;
  logic [CW-1:0] sym_cnt;
  logic          busy;
  logic          done;
  logic          err_overrun;

  modport master (
    input  in_start, csee_ready,
    output shift_fifo, hold_fifo, en_infifo, en_outfifo,
    output out_valid, sym_cnt, busy, done, err_overrun
  );

  modport slave (
    output in_start, csee_ready,
    input  shift_fifo, hold_fifo, en_infifo, en_outfifo,
    input  out_valid, sym_cnt, busy, done, err_overrun
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Sequencer for the 31-symbol receive FIFO: load a codeword, hold it, drain it alongside CSEE.
// FIFO controls are combinational (symbol 0 captured in the in_start cycle); status is registered.
// Drain waits in HOLD for csee_ready; in_start outside IDLE is dropped and flagged as overrun.
module fifo_ctrl
  import rs_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  fifo_ctrl_if.master   ctl
);

  fifo_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;

  logic          shift;
  logic          en_in;
  logic          en_out;

  // Next-state, counter and FIFO control decode; reset forces the FIFO into hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    shift   = 1'b0;
    en_in   = 1'b0;
    en_out  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctl.in_start) begin
          shift   = 1'b1;
          en_in   = 1'b1;
          cnt_d   = CW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        shift = 1'b1;
        en_in = 1'b1;
        if (cnt_q == LAST_SYM) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (ctl.csee_ready) begin
          shift   = 1'b1;
          en_out  = 1'b1;
          cnt_d   = CW'(1);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        shift  = 1'b1;
        en_out = 1'b1;
        // done is a flop; arm it one cycle early so it lines up with the last drain cycle
        if (cnt_q == PREV_SYM) begin
          done_d = 1'b1;
        end
        if (cnt_q == LAST_SYM) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (ctl.in_start && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end

    if (reset) begin
      shift  = 1'b0;
      en_in  = 1'b0;
      en_out = 1'b0;
    end
  end

  // State, symbol counter and registered status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= en_out;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign ctl.shift_fifo  = shift;
  assign ctl.hold_fifo   = ~shift;
  assign ctl.en_infifo   = en_in;
  assign ctl.en_outfifo  = en_out;
  assign ctl.out_valid   = out_valid_q;
  assign ctl.sym_cnt     = cnt_q;
  assign ctl.busy        = (state_q != IDLE);
  assign ctl.done        = done_q;
  assign ctl.err_overrun = ovr_q;

endmodule
